// File: rtl/checkpoint_recover_ctrl.sv
// Commit-side checkpoint recovery: on a mispredicting retire, restores the checkpoint, flushes the buffer and drains.
// Optional macro CHECKPOINT_RECOVER_STAT_EN adds a 32-bit recover_count statistic output.
module checkpoint_recover_ctrl #(
    parameter int COMMIT_WIDTH        = 2,
    parameter int CHECKPOINT_ID_WIDTH = 3,
    parameter int CP_DATA_WIDTH       = 32,
    parameter int DRAIN_CYCLES        = 2
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [COMMIT_WIDTH-1:0]                             rob_commit_valid,
    input  logic [COMMIT_WIDTH-1:0]                             rob_commit_has_cp,
    input  logic [COMMIT_WIDTH-1:0][CHECKPOINT_ID_WIDTH-1:0]    rob_commit_cp_id,
    input  logic [COMMIT_WIDTH-1:0]                             rob_commit_mispred,
    output logic [COMMIT_WIDTH-1:0][CHECKPOINT_ID_WIDTH-1:0]    commit_cpbuf_id,
    input  logic [COMMIT_WIDTH-1:0][CP_DATA_WIDTH-1:0]          cpbuf_commit_data,
    output logic [COMMIT_WIDTH-1:0]                             commit_cpbuf_pop,
    output logic                                                commit_cpbuf_flush,
    output logic                                                recover_valid,
    output logic [CP_DATA_WIDTH-1:0]                            recover_data,
    output logic                                                commit_stall
`ifdef CHECKPOINT_RECOVER_STAT_EN
    ,
    output logic [31:0]                                         recover_count
`endif
);

    typedef enum logic [1:0] {IDLE, RECOVER, DRAIN} state_t;

    state_t                    state_reg;
    logic [3:0]                drain_cnt_reg;
    logic [CP_DATA_WIDTH-1:0]  recover_data_reg;
    logic                      recover_valid_reg;
    logic                      flush_reg;

    logic [COMMIT_WIDTH-1:0]   qual;
    logic [COMMIT_WIDTH-1:0]   mis_q;
    logic [COMMIT_WIDTH-1:0]   mis_below;
    logic [COMMIT_WIDTH-1:0]   idle_pop;
    logic                      mis_any;
    logic                      in_idle;
    logic [CP_DATA_WIDTH-1:0]  mis_data;

    // mis_below[i] marks a qualified mispredict in some slot strictly below i.
    generate
        for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_slot
            assign commit_cpbuf_id[gi] = rob_commit_cp_id[gi];
            assign qual[gi]            = rob_commit_valid[gi] & rob_commit_has_cp[gi];
            assign mis_q[gi]           = qual[gi] & rob_commit_mispred[gi];
            if (gi == 0) begin : g_first
                assign mis_below[gi] = 1'b0;
            end else begin : g_rest
                assign mis_below[gi] = mis_below[gi-1] | mis_q[gi-1];
            end
            assign idle_pop[gi] = qual[gi] & ~mis_below[gi];
        end
    endgenerate

    assign mis_any = |mis_q;

    // Scanning downward leaves the lowest mispredicting slot's checkpoint selected.
    always_comb begin
        mis_data = '0;
        for (int i = COMMIT_WIDTH - 1; i >= 0; i--) begin
            if (mis_q[i]) begin
                mis_data = cpbuf_commit_data[i];
            end
        end
    end

    assign in_idle            = ~rst & (state_reg == IDLE);
    assign commit_cpbuf_pop   = in_idle ? idle_pop : '0;
    assign commit_stall       = ~in_idle;
    assign commit_cpbuf_flush = flush_reg;
    assign recover_valid      = recover_valid_reg;
    assign recover_data       = recover_data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            drain_cnt_reg     <= 4'd0;
            recover_data_reg  <= '0;
            recover_valid_reg <= 1'b0;
            flush_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mis_any) begin
                        state_reg         <= RECOVER;
                        recover_data_reg  <= mis_data;
                        recover_valid_reg <= 1'b1;
                        flush_reg         <= 1'b1;
                    end
                end
                RECOVER: begin
                    state_reg         <= DRAIN;
                    drain_cnt_reg     <= 4'(DRAIN_CYCLES);
                    recover_valid_reg <= 1'b0;
                    flush_reg         <= 1'b0;
                end
                DRAIN: begin
                    if (drain_cnt_reg <= 4'd1) begin
                        state_reg     <= IDLE;
                        drain_cnt_reg <= 4'd0;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg         <= IDLE;
                    recover_valid_reg <= 1'b0;
                    flush_reg         <= 1'b0;
                end
            endcase
        end
    end

`ifdef CHECKPOINT_RECOVER_STAT_EN
    logic [31:0] recover_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            recover_count_reg <= 32'd0;
        end else if (state_reg == RECOVER) begin
            recover_count_reg <= recover_count_reg + 32'd1;
        end
    end

    assign recover_count = recover_count_reg;
`endif

endmodule

// File: tb/tb_checkpoint_recover_ctrl.sv
// Bench for checkpoint_recover_ctrl: timeline-based reference model checked every cycle plus directed literal checks.
module tb_checkpoint_recover_ctrl;
    localparam int W  = 2;
    localparam int IW = 3;
    localparam int DW = 32;
    localparam int D  = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [W-1:0]           rob_commit_valid   = '0;
    logic [W-1:0]           rob_commit_has_cp  = '0;
    logic [W-1:0][IW-1:0]   rob_commit_cp_id   = '0;
    logic [W-1:0]           rob_commit_mispred = '0;
    logic [W-1:0][IW-1:0]   commit_cpbuf_id;
    logic [W-1:0][DW-1:0]   cpbuf_commit_data;
    logic [W-1:0]           commit_cpbuf_pop;
    logic                   commit_cpbuf_flush;
    logic                   recover_valid;
    logic [DW-1:0]          recover_data;
    logic                   commit_stall;
`ifdef CHECKPOINT_RECOVER_STAT_EN
    logic [31:0]            recover_count;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    checkpoint_recover_ctrl #(
        .COMMIT_WIDTH(W), .CHECKPOINT_ID_WIDTH(IW), .CP_DATA_WIDTH(DW), .DRAIN_CYCLES(D)
    ) dut (
        .clk(clk), .rst(rst),
        .rob_commit_valid(rob_commit_valid), .rob_commit_has_cp(rob_commit_has_cp),
        .rob_commit_cp_id(rob_commit_cp_id), .rob_commit_mispred(rob_commit_mispred),
        .commit_cpbuf_id(commit_cpbuf_id), .cpbuf_commit_data(cpbuf_commit_data),
        .commit_cpbuf_pop(commit_cpbuf_pop), .commit_cpbuf_flush(commit_cpbuf_flush),
        .recover_valid(recover_valid), .recover_data(recover_data),
        .commit_stall(commit_stall)
`ifdef CHECKPOINT_RECOVER_STAT_EN
        , .recover_count(recover_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] bufval(input logic [IW-1:0] id);
        return 32'hC0DE_0000 | (32'(id) * 32'h111);
    endfunction

    // The bench plays the checkpoint buffer: combinational read at the requested id.
    always_comb begin
        for (int i = 0; i < W; i++) cpbuf_commit_data[i] = bufval(commit_cpbuf_id[i]);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a recovery is a time window [N+1, N+1+D] after an accepted mispredict at cycle N.
    int            mis_cycle = -100;
    logic [DW-1:0] exp_data  = '0;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            bit           in_win, free, found;
            logic [W-1:0] e_pop;
            int           k;
            in_win = (cyc >= mis_cycle + 1) && (cyc <= mis_cycle + 1 + D);
            free   = !rst && !in_win;
            found  = 1'b0;
            k      = 0;
            e_pop  = '0;
            for (int i = 0; i < W; i++) begin
                bit q;
                q = rob_commit_valid[i] && rob_commit_has_cp[i];
                if (free && q && !found) e_pop[i] = 1'b1;
                if (q && rob_commit_mispred[i] && !found) begin
                    found = 1'b1;
                    k     = i;
                end
            end
            check("m_stall", 64'(commit_stall), 64'(rst || in_win));
            check("m_pop", 64'(commit_cpbuf_pop), 64'(e_pop));
            check("m_rv", 64'(recover_valid), 64'(cyc == mis_cycle + 1));
            check("m_flush", 64'(commit_cpbuf_flush), 64'(cyc == mis_cycle + 1));
            check("m_data", 64'(recover_data), 64'(exp_data));
            check("m_id", 64'(commit_cpbuf_id), 64'(rob_commit_cp_id));
            if (rst) begin
                mis_cycle = -100;
                exp_data  = '0;
            end else if (free && found) begin
                mis_cycle = cyc;
                exp_data  = bufval(rob_commit_cp_id[k]);
            end
        end
    end

    task automatic drive(input logic r, input logic [1:0] v, input logic [1:0] h,
                         input logic [1:0] m, input logic [2:0] id1, input logic [2:0] id0);
        @(posedge clk);
        #1;
        rst                = r;
        rob_commit_valid   = v;
        rob_commit_has_cp  = h;
        rob_commit_mispred = m;
        rob_commit_cp_id   = {id1, id0};
        @(negedge clk);
    endtask

    initial begin
        // Reset: stall high, no pops.
        drive(1, 2'b11, 2'b11, 2'b00, 3'd1, 3'd2);
        drive(1, 2'b11, 2'b11, 2'b01, 3'd1, 3'd2);
        check("rst_stall", 64'(commit_stall), 64'd1);
        check("rst_pop", 64'(commit_cpbuf_pop), 64'd0);
        check("rst_data", 64'(recover_data), 64'd0);

        // Both slots retire normally.
        drive(0, 2'b11, 2'b11, 2'b00, 3'd1, 3'd2);
        check("norm_pop", 64'(commit_cpbuf_pop), 64'h3);
        check("norm_stall", 64'(commit_stall), 64'd0);
        check("norm_flush", 64'(commit_cpbuf_flush), 64'd0);

        // Mispredict in slot 0 with checkpoint 3.
        drive(0, 2'b11, 2'b11, 2'b01, 3'd5, 3'd3);
        check("mis0_pop", 64'(commit_cpbuf_pop), 64'h1);
        drive(0, 2'b11, 2'b11, 2'b10, 3'd6, 3'd6);
        check("rec_valid", 64'(recover_valid), 64'd1);
        check("rec_flush", 64'(commit_cpbuf_flush), 64'd1);
        check("rec_data", 64'(recover_data), 64'hC0DE_0333);
        check("rec_stall", 64'(commit_stall), 64'd1);
        drive(0, 2'b11, 2'b11, 2'b10, 3'd6, 3'd6);
        check("drain_pop", 64'(commit_cpbuf_pop), 64'd0);
        check("drain_rv", 64'(recover_valid), 64'd0);
        drive(0, 2'b11, 2'b11, 2'b10, 3'd6, 3'd6);
        check("drain_stall", 64'(commit_stall), 64'd1);
        drive(0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0);
        check("idle_again", 64'(commit_stall), 64'd0);
        check("hold_data", 64'(recover_data), 64'hC0DE_0333);

        // Mispredict on a slot without a checkpoint is ignored.
        drive(0, 2'b11, 2'b10, 2'b01, 3'd4, 3'd7);
        check("unq_pop", 64'(commit_cpbuf_pop), 64'h2);
        drive(0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0);
        check("unq_rv", 64'(recover_valid), 64'd0);

        // Mispredict in slot 1 only.
        drive(0, 2'b11, 2'b11, 2'b10, 3'd6, 3'd1);
        check("mis1_pop", 64'(commit_cpbuf_pop), 64'h3);
        drive(0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0);
        check("mis1_data", 64'(recover_data), 64'hC0DE_0666);
        repeat (D) drive(0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0);

        // Reset during RECOVER.
        drive(0, 2'b01, 2'b01, 2'b01, 3'd0, 3'd2);
        drive(1, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0);
        drive(0, 2'b01, 2'b01, 2'b00, 3'd0, 3'd2);
        check("rstrec_rv", 64'(recover_valid), 64'd0);
        check("rstrec_flush", 64'(commit_cpbuf_flush), 64'd0);
        check("rstrec_data", 64'(recover_data), 64'd0);
        check("rstrec_stall", 64'(commit_stall), 64'd0);

        // Back-to-back mispredicts: accepted every D+2 cycles.
        repeat (3 * (D + 2)) drive(0, 2'b11, 2'b11, 2'b01, 3'd2, 3'd5);
        repeat (D + 3) drive(0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0);
        check("b2b_data", 64'(recover_data), 64'hC0DE_0555);
`ifdef CHECKPOINT_RECOVER_STAT_EN
        check("stat_count", 64'(recover_count), 64'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
